// File: rtl/bip_loader.sv
// bip_loader: host-to-BIP half of the serial link.
//   Receives a UART byte stream with an oversampling receiver clocked by the
//   shared baud tick, decodes it into a program image, writes the words into
//   BIP program memory and then pulses a start strobe to the processor.
//   Frame format: byte0 = N (word count, 0 ignored), then 2N bytes, each
//   word sent high byte first.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   i_baud_rate  one-clk baud tick, OVERSAMPLE ticks per bit
//   i_rx         serial line, idles high
//   o_mem_we     program memory write strobe (one clk per word)
//   o_mem_addr   program memory word address (held between writes)
//   o_mem_data   instruction word (held between writes)
//   o_bip_start  one-clk pulse once the whole program is written
//   o_busy       high from count-byte accept until start pulse or abort
//   o_err        one-clk pulse on framing error or inter-byte timeout
module bip_loader #(
   parameter int OVERSAMPLE = 16,
   parameter int TIMEOUT    = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_baud_rate,
   input  logic        i_rx,
   output logic        o_mem_we,
   output logic [7:0]  o_mem_addr,
   output logic [15:0] o_mem_data,
   output logic        o_bip_start,
   output logic        o_busy,
   output logic        o_err
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int OW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
   localparam logic [OW-1:0] TO_M1   = OW'(TIMEOUT - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {P_COUNT, P_HIGH, P_LOW, P_WRITE, P_START} p_state_t;

   // ---------------- input synchronizer ----------------
   logic r_rx_meta, r_rx_sync;

   // Reset to the idle level so no false start bit is seen out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   // ---------------- UART receiver ----------------
   rx_state_t       r_rx_state, w_rx_next;
   logic [TW-1:0]   r_tick;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic            w_tick_clr, w_tick_inc, w_shift_en, w_bit_clr;
   logic            w_byte_valid, w_frame_err;

   always_comb begin
      w_rx_next    = r_rx_state;
      w_tick_clr   = 1'b0;
      w_tick_inc   = 1'b0;
      w_shift_en   = 1'b0;
      w_bit_clr    = 1'b0;
      w_byte_valid = 1'b0;
      w_frame_err  = 1'b0;
      case (r_rx_state)
         R_IDLE: begin
            if (!r_rx_sync) begin
               w_rx_next  = R_START;
               w_tick_clr = 1'b1;
               w_bit_clr  = 1'b1;
            end
         end
         R_START: begin
            if (i_baud_rate) begin
               if (r_tick == HALF_M1) begin
                  // Mid start bit: a high line here means it was a glitch.
                  w_tick_clr = 1'b1;
                  w_rx_next  = r_rx_sync ? R_IDLE : R_DATA;
               end else begin
                  w_tick_inc = 1'b1;
               end
            end
         end
         R_DATA: begin
            if (i_baud_rate) begin
               if (r_tick == FULL_M1) begin
                  w_tick_clr = 1'b1;
                  w_shift_en = 1'b1;
                  if (r_bit == 3'd7) w_rx_next = R_STOP;
               end else begin
                  w_tick_inc = 1'b1;
               end
            end
         end
         R_STOP: begin
            if (i_baud_rate) begin
               if (r_tick == FULL_M1) begin
                  w_tick_clr   = 1'b1;
                  w_byte_valid = r_rx_sync;
                  w_frame_err  = ~r_rx_sync;
                  w_rx_next    = R_IDLE;
               end else begin
                  w_tick_inc = 1'b1;
               end
            end
         end
         default: w_rx_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state <= R_IDLE;
         r_tick     <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
      end else begin
         r_rx_state <= w_rx_next;
         if (w_tick_clr)      r_tick <= '0;
         else if (w_tick_inc) r_tick <= r_tick + 1'b1;
         if (w_bit_clr) begin
            r_bit <= '0;
         end else if (w_shift_en) begin
            r_bit   <= r_bit + 1'b1;
            r_shift <= {r_rx_sync, r_shift[7:1]};   // LSB first
         end
      end
   end

   // ---------------- frame parser ----------------
   p_state_t        r_pstate, w_p_next;
   logic [7:0]      r_n, r_addr, r_hi, r_mem_addr;
   logic [15:0]     r_mem_data;
   logic [OW-1:0]   r_to_cnt;
   logic            r_busy, r_err;
   logic            w_waiting, w_timeout, w_last;

   assign w_waiting = (r_pstate == P_HIGH) || (r_pstate == P_LOW);
   // A byte arriving on the same clk as the timeout wins.
   assign w_timeout = w_waiting && i_baud_rate && !w_byte_valid && (r_to_cnt == TO_M1);
   assign w_last    = (r_addr == r_n - 8'd1);

   always_comb begin
      w_p_next = r_pstate;
      case (r_pstate)
         P_COUNT: if (w_byte_valid && r_shift != 8'd0) w_p_next = P_HIGH;
         P_HIGH: begin
            if (w_byte_valid)   w_p_next = P_LOW;
            else if (w_timeout) w_p_next = P_COUNT;
         end
         P_LOW: begin
            if (w_byte_valid)   w_p_next = P_WRITE;
            else if (w_timeout) w_p_next = P_COUNT;
         end
         P_WRITE: w_p_next = w_last ? P_START : P_HIGH;
         P_START: w_p_next = P_COUNT;
         default: w_p_next = P_COUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pstate   <= P_COUNT;
         r_n        <= '0;
         r_addr     <= '0;
         r_hi       <= '0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
         r_to_cnt   <= '0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_pstate <= w_p_next;
         r_err    <= w_frame_err | w_timeout;
         if (!w_waiting || w_byte_valid || w_timeout) r_to_cnt <= '0;
         else if (i_baud_rate)                        r_to_cnt <= r_to_cnt + 1'b1;
         case (r_pstate)
            P_COUNT: begin
               if (w_byte_valid && r_shift != 8'd0) begin
                  r_n    <= r_shift;
                  r_addr <= '0;
                  r_busy <= 1'b1;
               end
            end
            P_HIGH: begin
               if (w_byte_valid)   r_hi   <= r_shift;
               else if (w_timeout) r_busy <= 1'b0;
            end
            P_LOW: begin
               // Output address/data are separate registers so they hold
               // across the address increment that follows the write.
               if (w_byte_valid) begin
                  r_mem_addr <= r_addr;
                  r_mem_data <= {r_hi, r_shift};
               end else if (w_timeout) begin
                  r_busy <= 1'b0;
               end
            end
            P_WRITE: if (!w_last) r_addr <= r_addr + 8'd1;
            P_START: r_busy <= 1'b0;
            default: ;
         endcase
      end
   end

   assign o_mem_we    = (r_pstate == P_WRITE);
   assign o_bip_start = (r_pstate == P_START);
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_data  = r_mem_data;
   assign o_busy      = r_busy;
   assign o_err       = r_err;

endmodule

// File: tb/tb_bip_loader.sv
// Directed testbench for bip_loader: serial frames are bit-banged on i_rx,
// and a negedge monitor logs memory writes, start pulses and error pulses.
module tb_bip_loader;

   localparam int OS = 8;
   localparam int TO = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        baud = 1'b0;
   logic        rx = 1'b1;
   logic        mem_we, bip_start, busy, err;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data;

   int tick_div = 1;
   int div_cnt  = 0;
   int errors   = 0;
   int checks   = 0;

   int          cyc = 0;
   logic [7:0]  wr_addr[$];
   logic [15:0] wr_data[$];
   int          wr_cyc[$];
   int          start_cnt = 0;
   int          start_cyc = 0;
   logic        start_busy = 1'b0;
   int          err_cnt = 0;
   int          we_nobusy = 0;

   bip_loader #(.OVERSAMPLE(OS), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst(rst), .i_baud_rate(baud), .i_rx(rx),
      .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
      .o_bip_start(bip_start), .o_busy(busy), .o_err(err)
   );

   always #5 clk = ~clk;

   // Baud tick: one clk high every tick_div clks, changed on the falling edge.
   always @(negedge clk) begin
      div_cnt = div_cnt + 1;
      if (div_cnt >= tick_div) begin
         div_cnt = 0;
         baud = 1'b1;
      end else begin
         baud = 1'b0;
      end
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mem_we) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_data);
         wr_cyc.push_back(cyc);
         if (!busy) we_nobusy = we_nobusy + 1;
         $display("write addr=%0d data=%h", mem_addr, mem_data);
      end
      if (bip_start) begin
         start_cnt  = start_cnt + 1;
         start_cyc  = cyc;
         start_busy = busy;
      end
      if (err) err_cnt = err_cnt + 1;
   end

   // Waits n baud ticks, returning 1 time unit after the clock edge.
   task automatic wait_ticks(input int n);
      int k = 0;
      while (k < n) begin
         @(posedge clk);
         if (baud) k++;
      end
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      wait_ticks(OS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_ticks(OS);
      end
      rx = stop_bit;
      wait_ticks(OS);
      rx = 1'b1;
      if (!stop_bit) wait_ticks(2 * OS);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", mem_we); end
      checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", mem_addr); end
      checks++; if (mem_data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", mem_data); end
      checks++; if (bip_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", bip_start); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      rst = 1'b0;
      wait_ticks(4);
   endtask

   task automatic test_basic();
      int wb = wr_addr.size();
      int sb = start_cnt;
      int eb = err_cnt;
      int nb = we_nobusy;
      tick_div = 2;
      wait_ticks(2);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_pre got=%b exp=0", busy); end
      send_byte(8'h02, 1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_count got=%b exp=1", busy); end
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'hAB, 1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_mid got=%b exp=1", busy); end
      send_byte(8'hCD, 1'b1);
      wait_ticks(8);
      checks++; if (wr_addr.size() - wb !== 2) begin errors++; $display("FAIL basic_nwrites got=%0d exp=2", wr_addr.size() - wb); end
      if (wr_addr.size() - wb >= 2) begin
         checks++; if (wr_addr[wb] !== 8'd0 || wr_data[wb] !== 16'h1234) begin errors++; $display("FAIL basic_w0 got=%0d/%h exp=0/1234", wr_addr[wb], wr_data[wb]); end
         checks++; if (wr_addr[wb+1] !== 8'd1 || wr_data[wb+1] !== 16'hABCD) begin errors++; $display("FAIL basic_w1 got=%0d/%h exp=1/abcd", wr_addr[wb+1], wr_data[wb+1]); end
         checks++; if (start_cyc !== wr_cyc[wb+1] + 1) begin errors++; $display("FAIL basic_start_lat got=%0d exp=%0d", start_cyc, wr_cyc[wb+1] + 1); end
      end
      checks++; if (start_cnt - sb !== 1) begin errors++; $display("FAIL basic_nstart got=%0d exp=1", start_cnt - sb); end
      checks++; if (start_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_at_start got=%b exp=1", start_busy); end
      checks++; if (we_nobusy !== nb) begin errors++; $display("FAIL basic_busy_at_write got=%0d exp=%0d", we_nobusy, nb); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_post got=%b exp=0", busy); end
      checks++; if (err_cnt !== eb) begin errors++; $display("FAIL basic_err got=%0d exp=%0d", err_cnt, eb); end
      tick_div = 1;
      wait_ticks(4);
   endtask

   task automatic test_zero_then_frame();
      int wb = wr_addr.size();
      int sb = start_cnt;
      int eb = err_cnt;
      send_byte(8'h00, 1'b1);
      wait_ticks(OS);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", busy); end
      send_byte(8'h01, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'hFF, 1'b1);
      wait_ticks(OS);
      checks++; if (wr_addr.size() - wb !== 1) begin errors++; $display("FAIL zero_nwrites got=%0d exp=1", wr_addr.size() - wb); end
      if (wr_addr.size() - wb >= 1) begin
         checks++; if (wr_addr[wb] !== 8'd0 || wr_data[wb] !== 16'hFFFF) begin errors++; $display("FAIL zero_w0 got=%0d/%h exp=0/ffff", wr_addr[wb], wr_data[wb]); end
      end
      checks++; if (start_cnt - sb !== 1) begin errors++; $display("FAIL zero_nstart got=%0d exp=1", start_cnt - sb); end
      checks++; if (err_cnt !== eb) begin errors++; $display("FAIL zero_err got=%0d exp=%0d", err_cnt, eb); end
   endtask

   task automatic test_framing_timeout();
      int wb = wr_addr.size();
      int sb = start_cnt;
      int eb = err_cnt;
      send_byte(8'h01, 1'b1);
      send_byte(8'h55, 1'b0);
      wait_ticks(4);
      checks++; if (err_cnt - eb !== 1) begin errors++; $display("FAIL frerr_count got=%0d exp=1", err_cnt - eb); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frerr_busy got=%b exp=1", busy); end
      wait_ticks(800);
      checks++; if (err_cnt - eb !== 1 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early got err=%0d busy=%b exp err=1 busy=1", err_cnt - eb, busy); end
      wait_ticks(300);
      checks++; if (err_cnt - eb !== 2) begin errors++; $display("FAIL timeout_err got=%0d exp=2", err_cnt - eb); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
      checks++; if (wr_addr.size() - wb !== 0) begin errors++; $display("FAIL timeout_writes got=%0d exp=0", wr_addr.size() - wb); end
      checks++; if (start_cnt - sb !== 0) begin errors++; $display("FAIL timeout_start got=%0d exp=0", start_cnt - sb); end
   endtask

   task automatic test_glitch();
      int wb = wr_addr.size();
      int eb = err_cnt;
      rx = 1'b0;
      wait_ticks(3);
      rx = 1'b1;
      wait_ticks(12 * OS);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b exp=0", busy); end
      checks++; if (err_cnt !== eb) begin errors++; $display("FAIL glitch_err got=%0d exp=%0d", err_cnt, eb); end
      checks++; if (wr_addr.size() !== wb) begin errors++; $display("FAIL glitch_writes got=%0d exp=%0d", wr_addr.size(), wb); end
   endtask

   task automatic test_reset_midframe();
      int wb = wr_addr.size();
      int sb = start_cnt;
      int eb = err_cnt;
      send_byte(8'h02, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      wait_ticks(2);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      wait_ticks(2 * OS);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h07, 1'b1);
      wait_ticks(OS);
      checks++; if (wr_addr.size() - wb !== 2) begin errors++; $display("FAIL rstmid_nwrites got=%0d exp=2", wr_addr.size() - wb); end
      if (wr_addr.size() - wb >= 2) begin
         checks++; if (wr_addr[wb] !== 8'd0 || wr_data[wb] !== 16'h1122) begin errors++; $display("FAIL rstmid_w_pre got=%0d/%h exp=0/1122", wr_addr[wb], wr_data[wb]); end
         checks++; if (wr_addr[wb+1] !== 8'd0 || wr_data[wb+1] !== 16'h0007) begin errors++; $display("FAIL rstmid_w0 got=%0d/%h exp=0/0007", wr_addr[wb+1], wr_data[wb+1]); end
      end
      checks++; if (start_cnt - sb !== 1) begin errors++; $display("FAIL rstmid_nstart got=%0d exp=1", start_cnt - sb); end
      checks++; if (err_cnt !== eb) begin errors++; $display("FAIL rstmid_err got=%0d exp=%0d", err_cnt, eb); end
   endtask

   task automatic test_n255();
      int wb = wr_addr.size();
      int sb = start_cnt;
      int n;
      logic [7:0] wv;
      send_byte(8'hFF, 1'b1);
      for (int w = 0; w < 255; w++) begin
         wv = w[7:0];
         send_byte(8'h00, 1'b1);
         send_byte(wv, 1'b1);
      end
      wait_ticks(4 * OS);
      n = wr_addr.size() - wb;
      checks++; if (n !== 255) begin errors++; $display("FAIL n255_nwrites got=%0d exp=255", n); end
      for (int i = 0; i < 255 && i < n; i++) begin
         wv = i[7:0];
         checks++; if (wr_addr[wb+i] !== wv || wr_data[wb+i] !== {8'h00, wv}) begin errors++; $display("FAIL n255_w%0d got=%0d/%h exp=%0d/%h", i, wr_addr[wb+i], wr_data[wb+i], wv, {8'h00, wv}); end
      end
      checks++; if (start_cnt - sb !== 1) begin errors++; $display("FAIL n255_nstart got=%0d exp=1", start_cnt - sb); end
      if (n >= 1) begin
         checks++; if (start_cyc !== wr_cyc[wb+n-1] + 1) begin errors++; $display("FAIL n255_start_lat got=%0d exp=%0d", start_cyc, wr_cyc[wb+n-1] + 1); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL n255_busy got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_then_frame();
      test_framing_timeout();
      test_glitch();
      test_reset_midframe();
      test_n255();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
